// File: rtl/hazard_fwd_unit_pkg.sv
// rtl/hazard_fwd_unit_pkg.sv - shared constants, tag layout and action enum for the hazard/forwarding unit
package hazard_fwd_unit_pkg;

    localparam int FWD_RF = 0;

    // Flattened tag layout, LSB first: ld, we, rd[REG_AW], valid. The bubble tag is all zeros.
    localparam int TAG_LD = 0;
    localparam int TAG_WE = 1;
    localparam int TAG_RD = 2;

    typedef enum logic [1:0] {
        ACT_RUN,
        ACT_STALL,
        ACT_FLUSH,
        ACT_HOLD
    } pipe_act_e;

    function automatic int tag_width(input int reg_aw);
        return reg_aw + 3;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// rtl/hazard_fwd_unit_if.sv - ID-side request and pipeline-control bundle of the hazard/forwarding unit
interface hazard_fwd_unit_if #(
    parameter int REG_AW = 5,
    parameter int NSRC   = 2,
    parameter int SW     = 2,
    parameter int CNT_W  = 16
);
    logic [NSRC*REG_AW-1:0] src_addr;
    logic [NSRC-1:0]        src_use;
    logic [REG_AW-1:0]      id_rd;
    logic                   id_rf_le;
    logic                   id_l;
    logic                   flush;
    logic                   hold;
    logic                   le;
    logic                   nop;
    logic [NSRC*SW-1:0]     fwd_s;
    logic [CNT_W-1:0]       stall_cnt;

    modport master (
        output src_addr, src_use, id_rd, id_rf_le, id_l, flush, hold,
        input  le, nop, fwd_s, stall_cnt
    );

    modport slave (
        input  src_addr, src_use, id_rd, id_rf_le, id_l, flush, hold,
        output le, nop, fwd_s, stall_cnt
    );
endinterface

// File: rtl/hazard_fwd_unit_fwd_src_select.sv
// rtl/hazard_fwd_unit_fwd_src_select.sv - per-operand youngest-match forwarding source and load-use stall
module fwd_src_select
    import hazard_fwd_unit_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NSTAGE     = 3,
    parameter int LOAD_STAGE = 1,
    parameter int SW         = $clog2(NSTAGE + 1)
) (
    input  logic [REG_AW-1:0]                    i_addr,
    input  logic                                 i_use,
    input  logic [NSTAGE*tag_width(REG_AW)-1:0]  i_tags,
    output logic                                 o_stall,
    output logic [SW-1:0]                        o_sel
);
    localparam int TW = tag_width(REG_AW);
    localparam int TV = TAG_RD + REG_AW;

    logic w_live;
    logic w_found;

    assign w_live = i_use && (i_addr != '0);

    // Ascending scan with a found flag so the youngest (lowest-index) writer wins.
    always_comb begin
        w_found = 1'b0;
        o_stall = 1'b0;
        o_sel   = SW'(FWD_RF);
        for (int i = 0; i < NSTAGE; i++) begin
            if (!w_found && w_live && i_tags[i*TW + TV] && i_tags[i*TW + TAG_WE]
                && (i_tags[i*TW + TAG_RD +: REG_AW] == i_addr)) begin
                w_found = 1'b1;
                if (i_tags[i*TW + TAG_LD] && (i < LOAD_STAGE)) begin
                    o_stall = 1'b1;
                end else begin
                    o_sel = SW'(i + 1);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// rtl/hazard_fwd_unit.sv - shadow tag pipeline, HOLD/FLUSH/hazard priority and saturating stall counter
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int NSTAGE     = 3,
    parameter int NSRC       = 2,
    parameter int LOAD_STAGE = 1,
    parameter int SW         = $clog2(NSTAGE + 1),
    parameter int CNT_W      = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    hazard_fwd_unit_if.slave  bus
);
    localparam int TW = tag_width(REG_AW);

    logic [NSTAGE*TW-1:0] r_tags;
    logic [CNT_W-1:0]     r_stall_cnt;

    logic [NSRC-1:0]      w_stall;
    logic [NSRC*SW-1:0]   w_fwd_s;
    logic                 w_hazard;
    logic                 w_le;
    logic                 w_nop;
    pipe_act_e            w_act;
    logic [TW-1:0]        w_id_tag;
    logic [TW-1:0]        w_ins_tag;

    generate
        for (genvar k = 0; k < NSRC; k++) begin : g_src
            fwd_src_select #(
                .REG_AW     (REG_AW),
                .NSTAGE     (NSTAGE),
                .LOAD_STAGE (LOAD_STAGE),
                .SW         (SW)
            ) u_sel (
                .i_addr  (bus.src_addr[k*REG_AW +: REG_AW]),
                .i_use   (bus.src_use[k]),
                .i_tags  (r_tags),
                .o_stall (w_stall[k]),
                .o_sel   (w_fwd_s[k*SW +: SW])
            );
        end
    endgenerate

    assign w_hazard = |w_stall;

    // A write to r0 is captured as a non-writer so it can never match a reader.
    assign w_id_tag  = {1'b1, bus.id_rd, bus.id_rf_le && (bus.id_rd != '0), bus.id_l};
    assign w_ins_tag = (w_act == ACT_RUN) ? w_id_tag : '0;

    always_comb begin
        w_act = ACT_RUN;
        w_le  = 1'b1;
        w_nop = 1'b0;
        if (bus.hold) begin
            w_act = ACT_HOLD;
            w_le  = 1'b0;
        end else if (bus.flush) begin
            w_act = ACT_FLUSH;
            w_nop = 1'b1;
        end else if (w_hazard) begin
            w_act = ACT_STALL;
            w_le  = 1'b0;
            w_nop = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tags      <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_act != ACT_HOLD) begin
                r_tags <= {r_tags[(NSTAGE-1)*TW-1:0], w_ins_tag};
            end
            if ((w_act == ACT_STALL) && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign bus.le        = w_le;
    assign bus.nop       = w_nop;
    assign bus.fwd_s     = w_fwd_s;
    assign bus.stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb/tb_hazard_fwd_unit.sv - directed scoreboard bench for default and NSTAGE=4/LOAD_STAGE=2 configurations
module tb_hazard_fwd_unit;

    logic clk;
    logic rst1;
    logic rst2;

    hazard_fwd_unit_if #(.REG_AW(5), .NSRC(2), .SW(2), .CNT_W(16)) if1 ();
    hazard_fwd_unit_if #(.REG_AW(5), .NSRC(2), .SW(3), .CNT_W(2))  if2 ();

    hazard_fwd_unit #(
        .REG_AW(5), .NSTAGE(3), .NSRC(2), .LOAD_STAGE(1), .SW(2), .CNT_W(16)
    ) u_dut1 (
        .i_clk (clk),
        .i_rst (rst1),
        .bus   (if1)
    );

    hazard_fwd_unit #(
        .REG_AW(5), .NSTAGE(4), .NSRC(2), .LOAD_STAGE(2), .SW(3), .CNT_W(2)
    ) u_dut2 (
        .i_clk (clk),
        .i_rst (rst2),
        .bus   (if2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [23:0] v;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_mis = 0;

    task automatic drive(input bit u, input logic [9:0] sa, input logic [1:0] su, input logic [4:0] rd,
                         input logic rfle, input logic ld, input logic fl, input logic hd);
        if (!u) begin
            if1.src_addr = sa; if1.src_use = su; if1.id_rd = rd;
            if1.id_rf_le = rfle; if1.id_l = ld; if1.flush = fl; if1.hold = hd;
        end else begin
            if2.src_addr = sa; if2.src_use = su; if2.id_rd = rd;
            if2.id_rf_le = rfle; if2.id_l = ld; if2.flush = fl; if2.hold = hd;
        end
    endtask

    task automatic check(input bit u);
        exp_t        e;
        logic [23:0] obs;
        @(negedge clk);
        n_cmp++;
        if (sb.size() == 0) begin
            n_mis++;
            $error("FAIL scoreboard_empty: no expected entry for unit %0d", u);
        end else begin
            e   = sb.pop_front();
            obs = u ? {if2.le, if2.nop, if2.fwd_s, 14'd0, if2.stall_cnt}
                    : {if1.le, if1.nop, 2'b00, if1.fwd_s, if1.stall_cnt};
            assert (obs === e.v) else begin
                n_mis++;
                $error("FAIL %s: got le=%0b nop=%0b fwd=%0h cnt=%0d, expected le=%0b nop=%0b fwd=%0h cnt=%0d",
                       e.tag, obs[23], obs[22], obs[21:16], obs[15:0],
                       e.v[23], e.v[22], e.v[21:16], e.v[15:0]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step(input bit u, input string tag,
                        input logic [9:0] sa, input logic [1:0] su, input logic [4:0] rd,
                        input logic rfle, input logic ld, input logic fl, input logic hd,
                        input logic ele, input logic enop, input logic [5:0] efwd, input logic [15:0] ecnt);
        exp_t e;
        drive(u, sa, su, rd, rfle, ld, fl, hd);
        e.tag = tag;
        e.v   = {ele, enop, efwd, ecnt};
        sb.push_back(e);
        check(u);
    endtask

    initial begin
        rst1 = 1'b1;
        rst2 = 1'b1;
        drive(0, 10'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1, 10'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;

        // Unit 1: NSTAGE=3, LOAD_STAGE=1
        step(0, "u1_reset_a", 10'd0, 2'b00, 5'd0, 0, 0, 0, 0, 1, 0, 6'd0, 16'd0);
        step(0, "u1_reset_b", 10'd0, 2'b00, 5'd0, 0, 0, 0, 0, 1, 0, 6'd0, 16'd0);
        rst1 = 1'b0;
        step(0, "u1_idle",    10'd0, 2'b00, 5'd0, 0, 0, 0, 0, 1, 0, 6'd0, 16'd0);
        step(0, "add_r3",     10'd0, 2'b00, 5'd3, 1, 0, 0, 0, 1, 0, 6'd0, 16'd0);
        step(0, "fwd_ex",     {5'd0, 5'd3}, 2'b01, 5'd0, 0, 0, 0, 0, 1, 0, 6'd1, 16'd0);
        step(0, "fwd_mem",    {5'd0, 5'd3}, 2'b01, 5'd0, 0, 0, 0, 0, 1, 0, 6'd2, 16'd0);
        step(0, "fwd_wb",     {5'd0, 5'd3}, 2'b01, 5'd0, 0, 0, 0, 0, 1, 0, 6'd3, 16'd0);
        step(0, "fwd_rf",     {5'd0, 5'd3}, 2'b01, 5'd0, 0, 0, 0, 0, 1, 0, 6'd0, 16'd0);
        step(0, "ld_r5",      10'd0, 2'b00, 5'd5, 1, 1, 0, 0, 1, 0, 6'd0, 16'd0);
        step(0, "lu_stall",   {5'd0, 5'd5}, 2'b01, 5'd0, 0, 0, 0, 0, 0, 1, 6'd0, 16'd0);
        step(0, "lu_fwd",     {5'd0, 5'd5}, 2'b01, 5'd0, 0, 0, 0, 0, 1, 0, 6'd2, 16'd1);
        step(0, "add_r3_a",   10'd0, 2'b00, 5'd3, 1, 0, 0, 0, 1, 0, 6'd0, 16'd1);
        step(0, "add_r3_b",   10'd0, 2'b00, 5'd3, 1, 0, 0, 0, 1, 0, 6'd0, 16'd1);
        step(0, "two_writers",{5'd0, 5'd3}, 2'b11, 5'd0, 0, 0, 0, 0, 1, 0, 6'h01, 16'd1);
        step(0, "two_src_mem",{5'd3, 5'd3}, 2'b11, 5'd0, 0, 0, 0, 0, 1, 0, 6'h0A, 16'd1);
        step(0, "ld_r7",      10'd0, 2'b00, 5'd7, 1, 1, 0, 0, 1, 0, 6'd0, 16'd1);
        step(0, "flush_lu",   {5'd0, 5'd7}, 2'b01, 5'd0, 0, 0, 1, 0, 1, 1, 6'd0, 16'd1);
        step(0, "ld_r7_b",    10'd0, 2'b00, 5'd7, 1, 1, 0, 0, 1, 0, 6'd0, 16'd1);
        for (int h = 0; h < 3; h++) begin
            step(0, $sformatf("hold_%0d", h), {5'd0, 5'd7}, 2'b01, 5'd0, 0, 0, 1, 1, 0, 0, 6'd0, 16'd1);
        end
        step(0, "post_hold_stall", {5'd0, 5'd7}, 2'b01, 5'd0, 0, 0, 0, 0, 0, 1, 6'd0, 16'd1);
        step(0, "post_hold_fwd",   {5'd0, 5'd7}, 2'b01, 5'd0, 0, 0, 0, 0, 1, 0, 6'd2, 16'd2);
        step(0, "ld_r9",      10'd0, 2'b00, 5'd9, 1, 1, 0, 0, 1, 0, 6'd0, 16'd2);
        rst1 = 1'b1;
        step(0, "rst_in_stall", {5'd0, 5'd9}, 2'b01, 5'd0, 0, 0, 0, 0, 0, 1, 6'd0, 16'd2);
        rst1 = 1'b0;
        step(0, "after_rst",  {5'd0, 5'd9}, 2'b01, 5'd0, 0, 0, 0, 0, 1, 0, 6'd0, 16'd0);
        step(0, "ld_r10",     10'd0, 2'b00, 5'd10, 1, 1, 0, 0, 1, 0, 6'd0, 16'd0);
        step(0, "both_stall", {5'd10, 5'd10}, 2'b11, 5'd0, 0, 0, 0, 0, 0, 1, 6'd0, 16'd0);
        step(0, "both_fwd",   {5'd10, 5'd10}, 2'b11, 5'd0, 0, 0, 0, 0, 1, 0, 6'h0A, 16'd1);
        drive(0, 10'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Unit 2: NSTAGE=4, LOAD_STAGE=2, 2-bit counter to reach saturation
        step(1, "u2_reset_a", 10'd0, 2'b00, 5'd0, 0, 0, 0, 0, 1, 0, 6'd0, 16'd0);
        step(1, "u2_reset_b", 10'd0, 2'b00, 5'd0, 0, 0, 0, 0, 1, 0, 6'd0, 16'd0);
        rst2 = 1'b0;
        step(1, "u2_ld_r4",   10'd0, 2'b00, 5'd4, 1, 1, 0, 0, 1, 0, 6'd0, 16'd0);
        step(1, "u2_stall_1", {5'd0, 5'd4}, 2'b01, 5'd0, 0, 0, 0, 0, 0, 1, 6'd0, 16'd0);
        step(1, "u2_stall_2", {5'd0, 5'd4}, 2'b01, 5'd0, 0, 0, 0, 0, 0, 1, 6'd0, 16'd1);
        step(1, "u2_fwd_wb",  {5'd0, 5'd4}, 2'b01, 5'd0, 0, 0, 0, 0, 1, 0, 6'd3, 16'd2);
        step(1, "u2_ld_r4_b", 10'd0, 2'b00, 5'd4, 1, 1, 0, 0, 1, 0, 6'd0, 16'd2);
        step(1, "u2_stall_3", {5'd0, 5'd4}, 2'b01, 5'd0, 0, 0, 0, 0, 0, 1, 6'd0, 16'd2);
        step(1, "u2_sat_hit", {5'd0, 5'd4}, 2'b01, 5'd0, 0, 0, 0, 0, 0, 1, 6'd0, 16'd3);
        step(1, "u2_sat_fwd", {5'd0, 5'd4}, 2'b01, 5'd0, 0, 0, 0, 0, 1, 0, 6'd3, 16'd3);
        step(1, "u2_ld_r4_c", 10'd0, 2'b00, 5'd4, 1, 1, 0, 0, 1, 0, 6'd0, 16'd3);
        step(1, "u2_sat_a",   {5'd0, 5'd4}, 2'b01, 5'd0, 0, 0, 0, 0, 0, 1, 6'd0, 16'd3);
        step(1, "u2_sat_b",   {5'd0, 5'd4}, 2'b01, 5'd0, 0, 0, 0, 0, 0, 1, 6'd0, 16'd3);
        step(1, "u2_sat_c",   {5'd0, 5'd4}, 2'b01, 5'd0, 0, 0, 0, 0, 1, 0, 6'd3, 16'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
